// File: rtl/rob_mp_pkg.sv
// rob_pkg: shared helpers for the multi-port reorder buffer (rob_mp).
// Optional feature macro used by the ROB files: ROB_EXCEPTION_EN.
package rob_pkg;

  // Number of ROB entries addressable by a tag of the given width.
  function automatic int rob_entries(input int tagw);
    return 1 << tagw;
  endfunction

  // dst field layout: low REGADDRW bits are the register address, and the
  // bit at position REGADDRW flags "instruction writes a register".
  function automatic int dst_valid_bit(input int regaddrw);
    return regaddrw;
  endfunction

endpackage

// Slices of the flattened writeback buses; they expect TAGW / DATAW in scope.
`ifndef ROB_SLICE_MACROS
`define ROB_SLICE_MACROS
`define ROB_TAG_SLICE(i) (i)*TAGW +: TAGW
`define ROB_VAL_SLICE(i) (i)*DATAW +: DATAW
`endif

// File: rtl/rob_mp_wb_merge.sv
// rob_wb_merge: folds the WBPORTS tag-broadcast buses into one write strobe
// and value for a single ROB entry; the highest matching port index wins.
// Optional feature macro: ROB_EXCEPTION_EN (adds the per-port exception bit).
module rob_wb_merge
  import rob_pkg::*;
#(
  parameter int DATAW     = 32,
  parameter int TAGW      = 6,
  parameter int WBPORTS   = 2,
  parameter int ENTRY_IDX = 0
) (
  input  logic [WBPORTS-1:0]       wb_en,
  input  logic [WBPORTS*TAGW-1:0]  wb_tag,
  input  logic [WBPORTS*DATAW-1:0] wb_value,
`ifdef ROB_EXCEPTION_EN
  input  logic [WBPORTS-1:0]       wb_exc,
  output logic                     hit_exc,
`endif
  output logic                     hit,
  output logic [DATAW-1:0]         hit_value
);

  // Scan ports in ascending order so a later (higher) match overrides.
  always_comb begin
    hit       = 1'b0;
    hit_value = '0;
`ifdef ROB_EXCEPTION_EN
    hit_exc   = 1'b0;
`endif
    for (int p = 0; p < WBPORTS; p++) begin
      if (wb_en[p] && (wb_tag[`ROB_TAG_SLICE(p)] == TAGW'(ENTRY_IDX))) begin
        hit       = 1'b1;
        hit_value = wb_value[`ROB_VAL_SLICE(p)];
`ifdef ROB_EXCEPTION_EN
        hit_exc   = wb_exc[p];
`endif
      end
    end
  end

endmodule

// File: rtl/rob_mp.sv
// rob_mp: parametrised reorder buffer with WBPORTS writeback buses, in-order
// single retire, true occupancy count, per-entry PC and synchronous flush.
// Optional feature macro: ROB_EXCEPTION_EN (per-entry exception bit; an
// excepting retire also discards every younger entry).
module rob_mp
  import rob_pkg::*;
#(
  parameter int DATAW    = 32,
  parameter int REGADDRW = 5,
  parameter int TAGW     = 6,
  parameter int WBPORTS  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     stall,
  input  logic                     alloc,
  input  logic [REGADDRW:0]        alloc_dst_reg,
  input  logic [DATAW-1:0]         alloc_pc,
  output logic [TAGW-1:0]          alloc_tag,
  input  logic [WBPORTS-1:0]       wb_en,
  input  logic [WBPORTS*TAGW-1:0]  wb_tag,
  input  logic [WBPORTS*DATAW-1:0] wb_value,
`ifdef ROB_EXCEPTION_EN
  input  logic [WBPORTS-1:0]       wb_exc,
  output logic                     retiring_exc,
`endif
  input  logic                     flush,
  output logic                     retiring,
  output logic [REGADDRW:0]        retiring_dst_reg,
  output logic [DATAW-1:0]         retiring_value,
  output logic [DATAW-1:0]         retiring_pc
);

  localparam int ENTRIES = rob_entries(TAGW);

  logic [TAGW-1:0]     head, tail;
  logic [TAGW:0]       count, count_nxt;
  logic [ENTRIES-1:0]  busy, done;
  logic [ENTRIES-1:0]  wb_hit, wb_accept;
  logic [DATAW-1:0]    wb_val    [ENTRIES];
  logic [DATAW-1:0]    value_mem [ENTRIES];
  logic [DATAW-1:0]    pc_mem    [ENTRIES];
  logic [REGADDRW:0]   dst_mem   [ENTRIES];
  logic                alloc_ok, retire_ok, exc_retire;
`ifdef ROB_EXCEPTION_EN
  logic [ENTRIES-1:0]  wb_hit_exc;
  logic [ENTRIES-1:0]  exc_mem;
`endif

  // Full and empty both have head == tail; only count tells them apart.
  assign stall     = (count == (TAGW+1)'(ENTRIES));
  assign alloc_tag = head;
  assign retire_ok = (count != '0) && done[tail];
`ifdef ROB_EXCEPTION_EN
  assign exc_retire = retire_ok && exc_mem[tail];
`else
  assign exc_retire = 1'b0;
`endif
  // An excepting retire keeps head where it is, so a same-cycle alloc is dropped.
  assign alloc_ok  = alloc && !stall && !exc_retire;
  // Results for entries that are not in flight are silently dropped.
  assign wb_accept = wb_hit & busy;

  // One priority merge per entry turns the tag buses into per-entry strobes.
  for (genvar e = 0; e < ENTRIES; e++) begin : g_merge
    rob_wb_merge #(
      .DATAW     (DATAW),
      .TAGW      (TAGW),
      .WBPORTS   (WBPORTS),
      .ENTRY_IDX (e)
    ) u_merge (
      .wb_en     (wb_en),
      .wb_tag    (wb_tag),
      .wb_value  (wb_value),
`ifdef ROB_EXCEPTION_EN
      .wb_exc    (wb_exc),
      .hit_exc   (wb_hit_exc[e]),
`endif
      .hit       (wb_hit[e]),
      .hit_value (wb_val[e])
    );
  end

  // Occupancy: +1 per accepted alloc, -1 per retire, zeroed by an exception.
  always_comb begin
    count_nxt = count;
    if (alloc_ok && !retire_ok) begin
      count_nxt = count + 1'b1;
    end else if (!alloc_ok && retire_ok) begin
      count_nxt = count - 1'b1;
    end
    if (exc_retire) begin
      count_nxt = '0;
    end
  end

  // Control state and retire outputs; flush outranks alloc, writeback, retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      busy             <= '0;
      done             <= '0;
      retiring         <= 1'b0;
      retiring_dst_reg <= '0;
      retiring_value   <= '0;
      retiring_pc      <= '0;
`ifdef ROB_EXCEPTION_EN
      retiring_exc     <= 1'b0;
`endif
    end else if (flush) begin
      busy     <= '0;
      done     <= '0;
      tail     <= head;
      count    <= '0;
      retiring <= 1'b0;
`ifdef ROB_EXCEPTION_EN
      retiring_exc <= 1'b0;
`endif
    end else begin
      retiring <= retire_ok;
`ifdef ROB_EXCEPTION_EN
      retiring_exc <= exc_retire;
`endif
      // done is registered, so a result written this edge retires next edge.
      done <= done | wb_accept;
      if (alloc_ok) begin
        busy[head] <= 1'b1;
        done[head] <= 1'b0;
        head       <= head + TAGW'(1);
      end
      if (retire_ok) begin
        retiring_dst_reg <= dst_mem[tail];
        retiring_value   <= value_mem[tail];
        retiring_pc      <= pc_mem[tail];
        busy[tail]       <= 1'b0;
        done[tail]       <= 1'b0;
        tail             <= tail + TAGW'(1);
      end
      if (exc_retire) begin
        busy <= '0;
        done <= '0;
        tail <= head;
      end
      count <= count_nxt;
    end
  end

  // Entry payload needs no reset: busy/done gate every use of it.
  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      dst_mem[head] <= alloc_dst_reg;
      pc_mem[head]  <= alloc_pc;
    end
    for (int e = 0; e < ENTRIES; e++) begin
      if (wb_accept[e]) begin
        value_mem[e] <= wb_val[e];
`ifdef ROB_EXCEPTION_EN
        exc_mem[e]   <= wb_hit_exc[e];
`endif
      end
    end
  end

endmodule

// File: doc/rob_mp.md
# rob_mp

Parametrised reorder buffer, successor to the single-port `rob`. Sits between rename/dispatch and the architectural register file.
- Allocates entries in program order and accepts results from `WBPORTS` parallel tag-broadcast buses.
- Retires the oldest completed entry each cycle.
- Uses a true occupancy count, so all `2^TAGW` entries are usable.
- Adds per-entry PC storage and a synchronous pipeline flush.

## Interface
Parameters:
- `DATAW`, 32, data and PC width
- `REGADDRW`, 5, architectural register address width; dst field is `REGADDRW+1` bits, MSB = "writes a register"
- `TAGW`, 6, tag width; `ENTRIES = 1<<TAGW`
- `WBPORTS`, 2, number of writeback broadcast ports (≥1)

Ports:
- `clk`  in  1  clock; one clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `stall`  out  1  buffer full (`count == ENTRIES`)
- `alloc`  in  1  allocate one entry this cycle
- `alloc_dst_reg`  in  `REGADDRW+1`  destination of allocating instruction
- `alloc_pc`  in  `DATAW`  PC of allocating instruction
- `alloc_tag`  out  `TAGW`  tag granted; combinational = `head`, valid in the `alloc` cycle
- `wb_en`  in  `WBPORTS`  per-port result valid
- `wb_tag`  in  `WBPORTS*TAGW`  flattened tags, port i at `[i*TAGW +: TAGW]`
- `wb_value`  in  `WBPORTS*DATAW`  flattened results
- `flush`  in  1  discard all entries
- `retiring`  out  1  one-cycle pulse, entry retired
- `retiring_dst_reg`  out  `REGADDRW+1`  retired destination
- `retiring_value`  out  `DATAW`  retired result
- `retiring_pc`  out  `DATAW`  retired PC

## Operation
- State:
  - `head`, `tail`: `TAGW` bits, wrap modulo `ENTRIES`.
  - `count`: `TAGW+1` bits, range 0..ENTRIES.
  - Per entry: `busy`, `done`, dst, pc, value.
- Alloc (`alloc && !stall`): entry[head] gets busy=1, done=0, dst, pc; `head++`. Alloc while `stall` is ignored; no state change.
- Writeback: for each port i with `wb_en[i]` and `busy[wb_tag_i]`, set done=1 and write the value.
  - Writes to non-busy tags are dropped.
  - Same tag on several ports in one cycle: highest port index wins.
- Retire: when `count != 0 && done[tail]` at the clock edge, register entry[tail] to the retiring outputs, clear busy/done, `tail++`.
- Count update: `+alloc_accepted − retired`; simultaneous alloc and retire leaves `count` unchanged.
- Flush has priority over alloc, writeback and retire in the same cycle. It clears all busy/done bits, sets `tail <= head`, `count <= 0`, `retiring <= 0`.
- No bypass: a writeback cannot make its entry retire in the same edge.

## Timing
- Reset values: `head=tail=0`, `count=0`, all busy/done 0, `stall=0`, `retiring=0`, `retiring_dst_reg=0`, `retiring_value=0`, `retiring_pc=0`. `alloc_tag=0` follows from `head=0`.
- `rst` asserted mid-operation aborts everything immediately, without waiting for a clock edge.
- Writeback accepted at edge N: that entry can retire at edge N+1 at the earliest, with `retiring` high the cycle after edge N+1.
- Throughput: 1 alloc, `WBPORTS` writebacks and 1 retire per cycle.
- `stall` is combinational from `count`. It deasserts in the cycle after a retire from full.
- Wrap-around: tag `ENTRIES-1` is followed by tag 0. Full and empty are distinguished only by `count`.

## Configuration
- `ROB_EXCEPTION_EN` defined:
  - Adds input `wb_exc` [`WBPORTS`], a per-entry exc bit, and output `retiring_exc`.
  - Retiring an entry with exc=1 pulses `retiring_exc` together with `retiring`.
  - The same edge discards all younger entries: `head` unchanged, `tail <= head`, `count <= 0`.
- `ROB_EXCEPTION_EN` undefined: those ports and storage are absent, and behaviour is exactly as above.

## Structure
- Shared package `rob_pkg`: `ENTRIES` derivation helper, dst-field layout (valid-bit position), flattened-port slice macros for tag and value.
- One sub-module, `rob_wb_merge`: per-entry priority merge of the `WBPORTS` buses into a single write-enable/value, highest index wins.
- Entry arrays and the head/tail/count control stay in `rob_mp`.

## Test plan
- Reset, then alloc 3 entries (dst 0x21, 0x22, 0x23): tags 0, 1, 2. Writeback tag 2 then 0 then 1 (values 0xA, 0xB, 0xC): retires in order with values 0xB, 0xC, 0xA, dst 0x21/0x22/0x23, one per cycle.
- Alloc 64 entries with TAGW=6: `stall`=1 and `count`=64. Alloc on the 65th cycle is ignored. Writeback tag 0: retire, and `stall` drops the next cycle. The next alloc gets tag 0 (wrap).
- Same-cycle writeback of tag 5 on port 0 (0x111) and port 1 (0x222): retires with 0x222.
- 10 entries outstanding with flush and alloc in the same cycle: `count=0`, `tail=head`, nothing retires. A later writeback to an old tag is dropped.
- With `ROB_EXCEPTION_EN`: 4 entries, tag 1 written back with exc=1, all done. Tag 0 retires normally, tag 1 retires with `retiring_exc`=1, tags 2–3 never retire, and `count`=0.
- Assert `rst` mid-stream between edges: outputs are 0 immediately, and the first alloc after release gets tag 0.
